// File: rtl/fpga_robots_game_sertx_arb.sv
// Two-requester round-robin arbiter feeding a baud-paced serial transmitter.
// A granted byte is framed as start bit, eight data bits LSB first, then one
// or two stop bits, each held for one baud1 interval on a flop-driven txd.
module fpga_robots_game_sertx_arb #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud1,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       txd,
    output logic       busy,
    output logic       last_grant
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    // Stop counter value that ends the frame; only one or two stop bits exist,
    // so a single-bit counter is enough.
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic       stopCnt_q, stopCnt_d;
    logic       txd_q, txd_d;
    logic       lastGrant_q, lastGrant_d;
    logic       grantIdx;
    logic       accept;

    // Arbitration: a lone requester wins; with both pending, the one that did
    // not win last time goes next. Ready is only offered while idle.
    always_comb begin
        grantIdx = 1'b0;
        if (req0_valid && req1_valid) begin
            grantIdx = ~lastGrant_q;
        end else if (req1_valid) begin
            grantIdx = 1'b1;
        end
        accept     = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grantIdx;
        req1_ready = accept && grantIdx;
    end

    // Frame sequencing. Every step after acceptance waits for baud1, so a
    // pulse landing in the acceptance cycle is simply not looked at.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        stopCnt_d   = stopCnt_q;
        txd_d       = txd_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d     = grantIdx ? req1_data : req0_data;
                    lastGrant_d = grantIdx;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (baud1) begin
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud1) begin
                    txd_d    = shift_q[0];
                    bitCnt_d = 3'd0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (baud1) begin
                    if (bitCnt_q != 3'd7) begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        txd_d    = shift_q[1];
                        bitCnt_d = bitCnt_q + 3'd1;
                    end else begin
                        txd_d     = 1'b1;
                        stopCnt_d = 1'b0;
                        state_d   = STOP;
                    end
                end
            end
            STOP: begin
                if (baud1) begin
                    if (stopCnt_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stopCnt_d = stopCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops the line to idle-high immediately and
    // primes last_grant so requester 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= 8'd0;
            bitCnt_q    <= 3'd0;
            stopCnt_q   <= 1'b0;
            txd_q       <= 1'b1;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            stopCnt_q   <= stopCnt_d;
            txd_q       <= txd_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE);
    assign last_grant = lastGrant_q;

endmodule
